// File: rtl/localmem_pkg.sv
// rtl/localmem_pkg.sv - width constants, access encodings and bank-slice helper for localmem
package localmem_pkg;

  localparam int MEM_ROWS        = 256;
  localparam int MEM_BANK_NUM    = 4;
  localparam int MEM_BANK_COLS   = 24;
  localparam int MEM_COLS        = MEM_BANK_NUM * MEM_BANK_COLS;
  localparam int MEM_BANK_SELECT = $clog2(MEM_BANK_NUM);
  localparam int MEM_ROW_BITS    = $clog2(MEM_ROWS);
  localparam int MEM_ADDR        = MEM_ROW_BITS + MEM_BANK_SELECT;

  typedef logic [MEM_COLS-1:0]        row_t;
  typedef logic [MEM_BANK_COLS-1:0]   bank_data_t;
  typedef logic [MEM_ROW_BITS-1:0]    row_addr_t;
  typedef logic [MEM_BANK_SELECT-1:0] bank_sel_t;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_READ  = 2'd2
  } acc_t;

  function automatic acc_t decode_access(input logic csb, input logic web);
    if (csb) return ACC_IDLE;
    return web ? ACC_READ : ACC_WRITE;
  endfunction

  function automatic bank_data_t bank_slice(input row_t row, input bank_sel_t bank);
    return row[int'(bank)*MEM_BANK_COLS +: MEM_BANK_COLS];
  endfunction

endpackage

// File: rtl/localmem_rowbuf.sv
// rtl/localmem_rowbuf.sv - one-row read buffer (tag, valid, data) with hit compare
// Valid only drops on reset; writes to the buffered row patch the data in place.
module localmem_rowbuf
  import localmem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic                    wr_en,
  input  logic [MEM_ROW_BITS-1:0] row,
  input  logic [MEM_COLS-1:0]     wr_data,
  input  logic [MEM_COLS-1:0]     arr_data,
  output logic                    hit,
  output logic [MEM_COLS-1:0]     buf_data
);

  localparam logic [0:0] ST_INVALID = 1'b0;
  localparam logic [0:0] ST_VALID   = 1'b1;

  logic [0:0]  state_q, state_d;
  row_addr_t   tag_q, tag_d;
  row_t        data_q, data_d;

  assign hit      = (state_q == ST_VALID) && (tag_q == row);
  assign buf_data = data_q;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (rd_en && !hit) begin
      state_d = ST_VALID;
      tag_d   = row;
      data_d  = arr_data;
    end else if (wr_en && hit) begin
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INVALID;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/localmem_bank_mem.sv
// rtl/localmem_bank_mem.sv - single-port banked local memory, 1-cycle burst/sequence reads
// Optional row buffer enabled by LOCALMEM_ROWBUF_EN.
module localmem_bank_mem
  import localmem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     CSB,
  input  logic                     WEB,
  input  logic                     OEB,
  input  logic [MEM_ADDR-1:0]      A,
  input  logic [MEM_COLS-1:0]      I,
  output logic [MEM_COLS-1:0]      O,
  output logic [MEM_BANK_COLS-1:0] SEQ_O,
  output logic                     rvalid,
  output logic                     arr_rd
);

  acc_t      acc;
  row_addr_t row;
  bank_sel_t bank;
  logic      rd_en;
  logic      wr_en;

  assign acc   = decode_access(CSB, WEB);
  assign row   = A[MEM_ADDR-1:MEM_BANK_SELECT];
  assign bank  = A[MEM_BANK_SELECT-1:0];
  assign rd_en = (acc == ACC_READ);
  assign wr_en = (acc == ACC_WRITE);

  logic [MEM_COLS-1:0] mem_q [MEM_ROWS];
  row_t                arr_data;

  // Storage is deliberately unreset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem_q[row] <= I;
  end

  assign arr_data = mem_q[row];

  row_t rd_data;
  logic use_array;

`ifdef LOCALMEM_ROWBUF_EN
  logic buf_hit;
  row_t buf_data;

  localmem_rowbuf u_rowbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .row      (row),
    .wr_data  (I),
    .arr_data (arr_data),
    .hit      (buf_hit),
    .buf_data (buf_data)
  );

  assign use_array = rd_en && !buf_hit;
  assign rd_data   = buf_hit ? buf_data : arr_data;
`else
  assign use_array = rd_en;
  assign rd_data   = arr_data;
`endif

  row_t      o_q, o_d;
  bank_sel_t bank_q, bank_d;
  logic      rvalid_q, rvalid_d;
  logic      arr_rd_q, arr_rd_d;

  always_comb begin
    o_d      = o_q;
    bank_d   = bank_q;
    rvalid_d = rd_en;
    arr_rd_d = use_array;
    if (rd_en) begin
      o_d    = rd_data;
      bank_d = bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q      <= '0;
      bank_q   <= '0;
      rvalid_q <= 1'b0;
      arr_rd_q <= 1'b0;
    end else begin
      o_q      <= o_d;
      bank_q   <= bank_d;
      rvalid_q <= rvalid_d;
      arr_rd_q <= arr_rd_d;
    end
  end

  assign O      = OEB ? '0 : o_q;
  assign SEQ_O  = OEB ? '0 : bank_slice(o_q, bank_q);
  assign rvalid = rvalid_q;
  assign arr_rd = arr_rd_q;

endmodule
